// File: rtl/arbiter_rr3.sv
// -----------------------------------------------------------------------------
// arbiter_rr3
//
// Three-client round-robin arbiter in front of a shared resource's select mux.
// A client that wins keeps a registered one-hot grant until it signals done,
// withdraws its request, or the hold watchdog revokes the grant. Each win
// rotates priority so that the winner becomes the lowest-priority client for
// the next arbitration.
//
// Valid/ready semantics: there is no separate valid/ready pair. req_i is a
// level that is sampled only on rising clk edges. gnt_o is the response and
// stays asserted for as long as the grant is held. done_i is sampled only
// while a grant is held and is ignored in IDLE.
//
// Parameters:
//   HOLD_MAX   maximum grant duration in cycles; 0 disables the watchdog
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req_i      per-client request level, bit k = client k
//   done_i     current owner releases the grant
//   gnt_o      registered one-hot grant, zero when nobody owns the resource
//   owner_o    index of the current owner, 0 when idle
//   busy_o     high while a grant is held (equals |gnt_o)
//   timeout_o  one-cycle pulse when the watchdog revokes a grant
//   prio_o     rotating priority mask, bit k = client k is in the first pass
//   state_o    debug view of the FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module arbiter_rr3 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       done_i,
    output logic [2:0] gnt_o,
    output logic [1:0] owner_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic [2:0] prio_o,
    output logic       state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // A zero-width counter is not legal, so a disabled watchdog still keeps a
    // single (unused) counter bit.
    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD_MAX);
    localparam logic [CW-1:0] CNT_LAST = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;

    state_t          state;
    logic [CW-1:0]   hold_cnt;
    logic [2:0]      prio_mask;

    logic [2:0]      masked_req;
    logic            have_win;
    logic [1:0]      winner;
    logic [2:0]      winner_onehot;
    logic [2:0]      winner_mask;
    logic            owner_req;
    logic            user_release;
    logic            wd_hit;

    // Lowest set index of a non-zero 3-bit vector.
    function automatic logic [1:0] lowest_idx(input logic [2:0] v);
        logic [1:0] idx;
        idx = 2'd2;
        if (v[1]) idx = 2'd1;
        if (v[0]) idx = 2'd0;
        return idx;
    endfunction

    // Two-pass search: clients still eligible in the mask first, then any
    // requester. A mask of 000 therefore hands priority back to client 0.
    always_comb begin
        masked_req = req_i & prio_mask;
        have_win   = 1'b0;
        winner     = 2'd0;
        if (masked_req != 3'b000) begin
            have_win = 1'b1;
            winner   = lowest_idx(masked_req);
        end else if (req_i != 3'b000) begin
            have_win = 1'b1;
            winner   = lowest_idx(req_i);
        end
    end

    // One-hot grant and the post-win mask (only clients above the winner).
    always_comb begin
        winner_onehot = 3'b000;
        winner_mask   = 3'b000;
        case (winner)
            2'd0: begin
                winner_onehot = 3'b001;
                winner_mask   = 3'b110;
            end
            2'd1: begin
                winner_onehot = 3'b010;
                winner_mask   = 3'b100;
            end
            2'd2: begin
                winner_onehot = 3'b100;
                winner_mask   = 3'b000;
            end
            default: begin
                winner_onehot = 3'b000;
                winner_mask   = 3'b000;
            end
        endcase
    end

    // The grant is one-hot, so ANDing it with req_i picks out the owner's
    // request bit without indexing by owner_o.
    always_comb begin
        owner_req    = |(req_i & gnt_o);
        user_release = done_i | ~owner_req;
        wd_hit       = (HOLD_MAX != 0) && (hold_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt_o     <= 3'b000;
            owner_o   <= 2'd0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
            prio_mask <= 3'b111;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_o <= 1'b0;
                    if (have_win) begin
                        state     <= GRANT;
                        gnt_o     <= winner_onehot;
                        owner_o   <= winner;
                        busy_o    <= 1'b1;
                        prio_mask <= winner_mask;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (user_release || wd_hit) begin
                        state     <= IDLE;
                        gnt_o     <= 3'b000;
                        owner_o   <= 2'd0;
                        busy_o    <= 1'b0;
                        hold_cnt  <= '0;
                        // An explicit release on the same edge wins over the
                        // watchdog, so no timeout is reported then.
                        timeout_o <= wd_hit && !user_release;
                    end else begin
                        timeout_o <= 1'b0;
                        if (hold_cnt != CNT_SAT) begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_o     <= 3'b000;
                    owner_o   <= 2'd0;
                    busy_o    <= 1'b0;
                    timeout_o <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

    assign prio_o  = prio_mask;
    assign state_o = state;

endmodule

// File: tb/tb_arbiter_rr3.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr3
//
// Directed bench for arbiter_rr3 with HOLD_MAX = 4. The driver applies one
// input vector per cycle and pushes the hand-computed output expected after the
// following rising edge. A monitor on the falling edge pops and compares.
// Reset behaviour is checked directly, because it does not wait for an edge.
// -----------------------------------------------------------------------------
module tb_arbiter_rr3;

    localparam int HOLD_MAX = 4;
    localparam int W        = 11;

    logic       clk;
    logic       rst;
    logic [2:0] req_i;
    logic       done_i;
    logic [2:0] gnt_o;
    logic [1:0] owner_o;
    logic       busy_o;
    logic       timeout_o;
    logic [2:0] prio_o;
    logic       state_o;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_pass;
    int           n_total;

    arbiter_rr3 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .owner_o   (owner_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .prio_o    (prio_o),
        .state_o   (state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pack_exp(input logic [2:0] gnt, input logic [1:0] owner,
                                              input logic to, input logic [2:0] prio);
        return {|gnt, gnt, owner, |gnt, to, prio};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {state_o, gnt_o, owner_o, busy_o, timeout_o, prio_o};
    endfunction

    task automatic check_now(input string name, input logic [W-1:0] exp);
        logic [W-1:0] act;
        act = dut_vec();
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {st,gnt,own,busy,to,prio}=%b required %b", name, act, exp);
    endtask

    // Apply inputs for the current cycle and queue the expected post-edge state.
    task automatic drive(input logic [2:0] req, input logic done, input logic [2:0] gnt,
                         input logic [1:0] owner, input logic to, input logic [2:0] prio,
                         input string name);
        req_i  = req;
        done_i = done;
        exp_q.push_back(pack_exp(gnt, owner, to, prio));
        name_q.push_back(name);
    endtask

    task automatic step(input logic [2:0] req, input logic done, input logic [2:0] gnt,
                        input logic [1:0] owner, input logic to, input logic [2:0] prio,
                        input string name);
        @(negedge clk);
        #1;
        drive(req, done, gnt, owner, to, prio, name);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check_now(name_q.pop_front(), exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        req_i   = 3'b111;
        done_i  = 1'b0;

        // Reset held with all clients requesting: nothing granted.
        repeat (2) @(negedge clk);
        #2;
        check_now("reset_hold", pack_exp(3'b000, 2'd0, 1'b0, 3'b111));

        @(negedge clk);
        #1;
        rst = 1'b1;
        drive(3'b111, 1'b0, 3'b001, 2'd0, 1'b0, 3'b110, "reset_release_g0");

        // Full rotation with req=111 and done pulsed while busy.
        step(3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b110, "rot_rel0");
        step(3'b111, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "rot_g1");
        step(3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b100, "rot_rel1");
        step(3'b111, 1'b0, 3'b100, 2'd2, 1'b0, 3'b000, "rot_g2");
        step(3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, "rot_rel2");
        step(3'b111, 1'b0, 3'b001, 2'd0, 1'b0, 3'b110, "rot_g0_wrap");
        step(3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b110, "rot_rel0b");

        // Withdrawal by client 1, then req=101 goes to client 2.
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "wd_g1");
        step(3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b100, "withdraw_rel");
        step(3'b101, 1'b0, 3'b100, 2'd2, 1'b0, 3'b000, "after_withdraw_g2");
        step(3'b101, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, "after_withdraw_rel");

        // Watchdog: client 1 holds with no done; grant lasts exactly 4 cycles.
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "wdog_g1");
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "wdog_hold1");
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "wdog_hold2");
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "wdog_hold3");
        step(3'b010, 1'b0, 3'b000, 2'd0, 1'b1, 3'b100, "wdog_timeout");
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "wdog_regrant");

        // Simultaneous done and watchdog in the 4th grant cycle: no timeout.
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "sim_hold1");
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "sim_hold2");
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "sim_hold3");
        step(3'b010, 1'b1, 3'b000, 2'd0, 1'b0, 3'b100, "sim_release");

        // Non-owner requests are ignored during a grant.
        step(3'b001, 1'b0, 3'b001, 2'd0, 1'b0, 3'b110, "nonowner_g0");
        step(3'b011, 1'b0, 3'b001, 2'd0, 1'b0, 3'b110, "nonowner_ignored");
        step(3'b010, 1'b0, 3'b000, 2'd0, 1'b0, 3'b110, "nonowner_withdraw0");
        step(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "nonowner_g1");
        step(3'b010, 1'b1, 3'b000, 2'd0, 1'b0, 3'b100, "nonowner_rel1");
        step(3'b100, 1'b0, 3'b100, 2'd2, 1'b0, 3'b000, "pre_async_g2");

        // Async reset between edges while client 2 owns the grant.
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_now("async_reset_mid_grant", pack_exp(3'b000, 2'd0, 1'b0, 3'b111));
        @(negedge clk);
        #1;
        rst = 1'b1;
        drive(3'b110, 1'b0, 3'b010, 2'd1, 1'b0, 3'b100, "post_reset_g1");
        step(3'b110, 1'b1, 3'b000, 2'd0, 1'b0, 3'b100, "post_reset_rel");

        // A request pulse that never spans a rising edge is not granted.
        @(negedge clk);
        #1;
        req_i = 3'b001;
        #2;
        drive(3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b100, "glitch_not_granted");
        step(3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b100, "idle_no_req");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
